// File: rtl/add_accumulator_pkg.sv
// rtl/add_accumulator_pkg.sv - shared state type and counter-width helper for add_accumulator
package acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

    // Counter must be able to hold LEN itself, shown on out_count while DONE
    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/add_accumulator_if.sv
// rtl/add_accumulator_if.sv - sample input stream and frame result stream of add_accumulator
interface add_accumulator_if #(
    parameter int N   = 8,
    parameter int LEN = 4
);
    import acc_pkg::*;

    localparam int CNT_W = cnt_w(LEN);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_carry;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_count
    );

endinterface

// File: rtl/add_accumulator_fa_nbit.sv
// rtl/add_accumulator_fa_nbit.sv - N-bit ripple-carry adder built from full-adder cells
module FA_Nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/add_accumulator.sv
// rtl/add_accumulator.sv - frame accumulator over LEN samples; ACC_SATURATE_EN clamps the total on overflow
module add_accumulator
    import acc_pkg::*;
#(
    parameter int N   = 8,
    parameter int LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    add_accumulator_if.slave  bus
);

    localparam int               CNT_W = cnt_w(LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

    acc_state_t       state, state_next;
    logic [N-1:0]     acc, acc_next;
    logic             carry, carry_next;
    logic [CNT_W-1:0] count, count_next;
    logic [N-1:0]     add_sum;
    logic             add_cout;

    FA_Nbit #(.N(N)) u_adder (
        .a    (acc),
        .b    (bus.in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Handshake flags come from state alone, so neither ready nor valid sees the other side combinationally
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = acc;
    assign bus.out_carry = carry;
    assign bus.out_count = count;

    always_comb begin
        state_next = state;
        acc_next   = acc;
        carry_next = carry;
        count_next = count;
        case (state)
            ACCUM: begin
                if (bus.in_valid) begin
`ifdef ACC_SATURATE_EN
                    acc_next = add_cout ? {N{1'b1}} : add_sum;
`else
                    acc_next = add_sum;
`endif
                    carry_next = carry | add_cout;
                    count_next = count + CNT_W'(1);
                    if (count == LAST) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = ACCUM;
                    acc_next   = '0;
                    carry_next = 1'b0;
                    count_next = '0;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            carry <= carry_next;
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_add_accumulator.sv
// tb/tb_add_accumulator.sv - directed and random checks of add_accumulator against a frame-level model
module tb_add_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_accumulator_if #(.N(8), .LEN(4)) bus ();
    add_accumulator_if #(.N(8), .LEN(1)) bus1 ();

    add_accumulator #(.N(8), .LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    add_accumulator #(.N(8), .LEN(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

`ifdef ACC_SATURATE_EN
    localparam int OVF_SUM = 255;
`else
    localparam int OVF_SUM = 44;
`endif

    // Frame-level model: accepted samples of the open frame, and the pending result if any
    int m_samples[$];
    bit m_pending = 1'b0;
    int m_sum = 0;
    bit m_carry = 1'b0;

    function automatic void model_frame();
        int a;
        a = 0;
        m_carry = 1'b0;
        foreach (m_samples[i]) begin
            a += m_samples[i];
            if (a > 255) begin
                m_carry = 1'b1;
`ifdef ACC_SATURATE_EN
                a = 255;
`else
                a -= 256;
`endif
            end
        end
        m_sum = a;
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_pending) begin
                if (bus.out_ready) begin
                    m_pending = 1'b0;
                    m_samples.delete();
                end
            end else if (bus.in_valid) begin
                m_samples.push_back(int'(bus.in_data));
                if (m_samples.size() == 4) begin
                    model_frame();
                    m_pending = 1'b1;
                end
            end
        end
    end

    always @(negedge rst_n) begin
        m_samples.delete();
        m_pending = 1'b0;
    end

    always @(negedge clk) begin
        chk("in_ready", int'(bus.in_ready), int'(!m_pending));
        chk("out_valid", int'(bus.out_valid), int'(m_pending));
        if (m_pending) begin
            chk("out_sum", int'(bus.out_sum), m_sum);
            chk("out_carry", int'(bus.out_carry), int'(m_carry));
            chk("out_count_done", int'(bus.out_count), 4);
        end else begin
            chk("out_count", int'(bus.out_count), m_samples.size());
        end
    end

    task automatic send(input int d);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(d);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) chk("out_timeout", 0, 1);
    endtask

    initial begin
        int v[7];
        int d[7];
        v = '{1, 0, 0, 1, 0, 1, 1};
        d = '{1, 0, 0, 2, 0, 3, 4};

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b1;

        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_sum", int'(bus.out_sum), 0);
        chk("rst_out_carry", int'(bus.out_carry), 0);
        chk("rst_out_count", int'(bus.out_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame: result visible one cycle after the 4th accept
        send(10); send(20); send(30); send(40);
        chk("t1_latency", int'(bus.out_valid), 1);
        chk("t1_sum", int'(bus.out_sum), 100);
        chk("t1_carry", int'(bus.out_carry), 0);
        chk("t1_count", int'(bus.out_count), 4);
        @(negedge clk);
        chk("t1_back_ready", int'(bus.in_ready), 1);

        // Overflow
        send(200); send(100); send(0); send(0);
        wait_out();
        chk("t2_sum", int'(bus.out_sum), OVF_SUM);
        chk("t2_carry", int'(bus.out_carry), 1);
        @(negedge clk);

        // Backpressure with an offered sample that must be ignored
        bus.out_ready = 1'b0;
        send(1); send(2); send(3); send(4);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid", int'(bus.out_valid), 1);
            chk("t3_ready", int'(bus.in_ready), 0);
            chk("t3_sum", int'(bus.out_sum), 10);
            chk("t3_count", int'(bus.out_count), 4);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t3_release_ready", int'(bus.in_ready), 1);
        chk("t3_release_count", int'(bus.out_count), 0);
        chk("t3_release_valid", int'(bus.out_valid), 0);

        // Input gaps
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = v[i][0];
            bus.in_data  = (v[i] != 0) ? 8'(d[i]) : 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        wait_out();
        chk("t4_sum", int'(bus.out_sum), 10);
        @(negedge clk);

        // Asynchronous reset mid-frame
        send(7); send(8);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", int'(bus.out_valid), 0);
        chk("t5_rst_ready", int'(bus.in_ready), 1);
        chk("t5_rst_count", int'(bus.out_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(5); send(5); send(5); send(5);
        wait_out();
        chk("t5_sum", int'(bus.out_sum), 20);
        @(negedge clk);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_data   = 8'($urandom);
            bus.out_ready = ($urandom % 3) != 0;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // LEN=1 instance: one result every two cycles
        bus1.in_valid = 1'b1;
        bus1.in_data  = 8'd7;
        @(negedge clk);
        chk("t6_valid_a", int'(bus1.out_valid), 1);
        chk("t6_sum_a", int'(bus1.out_sum), 7);
        chk("t6_carry_a", int'(bus1.out_carry), 0);
        chk("t6_count_a", int'(bus1.out_count), 1);
        chk("t6_ready_a", int'(bus1.in_ready), 0);
        bus1.in_data = 8'd9;
        @(negedge clk);
        chk("t6_gap_valid", int'(bus1.out_valid), 0);
        chk("t6_gap_ready", int'(bus1.in_ready), 1);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        chk("t6_valid_b", int'(bus1.out_valid), 1);
        chk("t6_sum_b", int'(bus1.out_sum), 9);
        chk("t6_carry_b", int'(bus1.out_carry), 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
